// File: rtl/cc_pkg.sv
// cc_pkg: shared NZP type, condition-code constants and the bus-value classifier
// used by the condition-code / branch-enable unit.
`default_nettype none

package cc_pkg;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

    // Callers pass the sign bit and a zero test, so one function serves any data width.
    function automatic nzp_t classify(input logic sign_bit, input logic is_zero);
        if (sign_bit)
            return NZP_N;
        else if (is_zero)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cc_branch_unit_if.sv
// cc_branch_unit_if: control inputs and status outputs of the condition-code /
// branch-enable unit, with master (control FSM side) and slave (unit side) views.
`default_nettype none

interface cc_branch_unit_if #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
);
    import cc_pkg::*;

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               LD_CC;
    logic               LD_BEN;
    logic [DATA_W-1:0]  cc_data;
    logic [2:0]         IR_11_9;
    logic               cc_push;
    logic               cc_pop;
    logic               err_clr;
    nzp_t               nzp;
    logic               ben_output;
    logic               ben_valid;
    logic [DEPTH_W-1:0] cc_depth;
    logic               stack_full;
    logic               stack_empty;
    logic               ovf_err;
    logic               unf_err;

    modport master (
        output LD_CC, LD_BEN, cc_data, IR_11_9, cc_push, cc_pop, err_clr,
        input  nzp, ben_output, ben_valid, cc_depth, stack_full, stack_empty,
               ovf_err, unf_err
    );

    modport slave (
        input  LD_CC, LD_BEN, cc_data, IR_11_9, cc_push, cc_pop, err_clr,
        output nzp, ben_output, ben_valid, cc_depth, stack_full, stack_empty,
               ovf_err, unf_err
    );

endinterface

`default_nettype wire

// File: rtl/cc_stack.sv
// cc_stack: LIFO of saved NZP codes for interrupt entry / RTI, with depth
// tracking, full/empty status and sticky overflow/underflow flags.
`default_nettype none

module cc_stack
    import cc_pkg::*;
#(
    parameter  int STACK_DEPTH = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               push,
    input  wire logic               pop,
    input  wire logic               err_clr,
    input  wire nzp_t               nzp_in,
    output nzp_t                    top,
    output logic                    pop_valid,
    output logic [DEPTH_W-1:0]      depth,
    output logic                    full,
    output logic                    empty,
    output logic                    ovf_err,
    output logic                    unf_err
);

    localparam int ADDR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    nzp_t               slots [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [ADDR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0]  rd_idx;
    logic               push_valid;
    logic               ovf_set;
    logic               unf_set;
    logic               ovf_q;
    logic               unf_q;

    assign full       = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty      = (depth_q == '0);
    assign wr_idx     = ADDR_W'(depth_q);
    assign rd_idx     = ADDR_W'(depth_q - DEPTH_W'(1));

    // Simultaneous push and pop is treated as a protocol error: neither takes effect.
    assign push_valid = push && !pop && !full;
    assign pop_valid  = pop && !push && !empty;
    assign ovf_set    = push && (pop || full);
    assign unf_set    = pop && !push && empty;

    assign top        = slots[rd_idx];

    // Slot contents carry no reset: they are only read below a valid depth.
    always_ff @(posedge clk) begin
        if (push_valid)
            slots[wr_idx] <= nzp_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (push_valid)
                depth_q <= depth_q + DEPTH_W'(1);
            else if (pop_valid)
                depth_q <= depth_q - DEPTH_W'(1);

            // A fresh error outranks a clear arriving in the same cycle.
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (err_clr)
                ovf_q <= 1'b0;

            if (unf_set)
                unf_q <= 1'b1;
            else if (err_clr)
                unf_q <= 1'b0;
        end
    end

    assign depth   = depth_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

`default_nettype wire

// File: rtl/cc_branch_unit.sv
// cc_branch_unit: classifies the bus value into NZP, holds the NZP and BEN
// registers, and wraps the NZP save/restore stack used on interrupt entry / RTI.
`default_nettype none

module cc_branch_unit
    import cc_pkg::*;
#(
    parameter int   DATA_W      = 16,
    parameter int   STACK_DEPTH = 4,
    parameter nzp_t RESET_NZP   = 3'b010,
    parameter bit   BEN_BYPASS  = 1'b0
) (
    input  wire logic       Clk,
    input  wire logic       reset_n,
    cc_branch_unit_if.slave bus
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [DATA_W-1:0]  data;
    nzp_t               cc_class;
    nzp_t               nzp_q;
    nzp_t               stack_top;
    nzp_t               ben_src;
    logic               pop_valid;
    logic               ben_q;
    logic               ben_valid_q;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;
    logic               ovf_err;
    logic               unf_err;

    assign data     = bus.cc_data;
    assign cc_class = classify(data[DATA_W-1], data == '0);

    cc_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (Clk),
        .rst_n     (reset_n),
        .push      (bus.cc_push),
        .pop       (bus.cc_pop),
        .err_clr   (bus.err_clr),
        .nzp_in    (nzp_q),
        .top       (stack_top),
        .pop_valid (pop_valid),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    // With bypass, BEN sees the value NZP is about to take, unless a restore overrides it.
    generate
        if (BEN_BYPASS) begin : g_bypass
            assign ben_src = (bus.LD_CC && !pop_valid) ? cc_class : nzp_q;
        end else begin : g_no_bypass
            assign ben_src = nzp_q;
        end
    endgenerate

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            nzp_q       <= RESET_NZP;
            ben_q       <= 1'b0;
            ben_valid_q <= 1'b0;
        end else begin
            if (pop_valid)
                nzp_q <= stack_top;
            else if (bus.LD_CC)
                nzp_q <= cc_class;

            if (bus.LD_BEN)
                ben_q <= |(ben_src & bus.IR_11_9);

            ben_valid_q <= bus.LD_BEN;
        end
    end

    assign bus.nzp         = nzp_q;
    assign bus.ben_output  = ben_q;
    assign bus.ben_valid   = ben_valid_q;
    assign bus.cc_depth    = depth;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf_err     = ovf_err;
    assign bus.unf_err     = unf_err;

endmodule

`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
// tb_cc_branch_unit: directed bench driving a non-bypass and a bypass instance
// of cc_branch_unit in lockstep with hand-computed expectations.
`default_nettype none

module tb_cc_branch_unit;
    import cc_pkg::*;

    logic Clk;
    logic reset_n;
    int   checks;
    int   errors;

    cc_branch_unit_if #(.DATA_W(16), .STACK_DEPTH(4)) b0 ();
    cc_branch_unit_if #(.DATA_W(16), .STACK_DEPTH(4)) b1 ();

    cc_branch_unit #(.DATA_W(16), .STACK_DEPTH(4), .RESET_NZP(3'b010), .BEN_BYPASS(1'b0)) u_dut0 (
        .Clk     (Clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    cc_branch_unit #(.DATA_W(16), .STACK_DEPTH(4), .RESET_NZP(3'b010), .BEN_BYPASS(1'b1)) u_dut1 (
        .Clk     (Clk),
        .reset_n (reset_n),
        .bus     (b1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic ld_cc, input logic ld_ben, input logic [15:0] data,
                         input logic [2:0] ir, input logic push, input logic pop,
                         input logic clr);
        b0.LD_CC = ld_cc;  b0.LD_BEN = ld_ben; b0.cc_data = data; b0.IR_11_9 = ir;
        b0.cc_push = push; b0.cc_pop = pop;    b0.err_clr = clr;
        b1.LD_CC = ld_cc;  b1.LD_BEN = ld_ben; b1.cc_data = data; b1.IR_11_9 = ir;
        b1.cc_push = push; b1.cc_pop = pop;    b1.err_clr = clr;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 0, 16'h0000, 3'b000, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (b0.nzp !== 3'b010 || b1.nzp !== 3'b010) begin
            errors++;
            $display("FAIL reset_nzp: got %b/%b, expected 010", b0.nzp, b1.nzp);
        end
        checks++;
        if (b0.ben_output !== 1'b0 || b0.ben_valid !== 1'b0 || b1.ben_output !== 1'b0) begin
            errors++;
            $display("FAIL reset_ben: got ben=%b valid=%b, expected 0 0", b0.ben_output, b0.ben_valid);
        end
        checks++;
        if (b0.cc_depth !== 3'd0 || b0.stack_empty !== 1'b1 || b0.stack_full !== 1'b0 ||
            b0.ovf_err !== 1'b0 || b0.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_stack: got depth=%0d empty=%b full=%b ovf=%b unf=%b, expected 0 1 0 0 0",
                     b0.cc_depth, b0.stack_empty, b0.stack_full, b0.ovf_err, b0.unf_err);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (b0.nzp !== 3'b010 || b0.ben_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got nzp=%b valid=%b, expected 010 0", b0.nzp, b0.ben_valid);
        end
    endtask

    task automatic test_classify();
        logic [15:0] data_v [4];
        nzp_t        exp_v  [4];
        data_v = '{16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
        exp_v  = '{3'b100,   3'b010,   3'b001,   3'b001};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, data_v[i], 3'b000, 0, 0, 0);
            tick();
            checks++;
            if (b0.nzp !== exp_v[i] || b1.nzp !== exp_v[i]) begin
                errors++;
                $display("FAIL classify_%0d: data=%h got %b/%b, expected %b",
                         i, data_v[i], b0.nzp, b1.nzp, exp_v[i]);
            end
        end
        drive(0, 0, 16'h8000, 3'b000, 0, 0, 0);
        tick();
        checks++;
        if (b0.nzp !== 3'b001) begin
            errors++;
            $display("FAIL classify_hold: got %b, expected 001", b0.nzp);
        end
    endtask

    task automatic test_ben();
        drive(1, 0, 16'h0000, 3'b000, 0, 0, 0);
        tick();
        drive(0, 1, 16'h0000, 3'b010, 0, 0, 0);
        tick();
        checks++;
        if (b0.ben_output !== 1'b1 || b0.ben_valid !== 1'b1 || b1.ben_output !== 1'b1) begin
            errors++;
            $display("FAIL ben_match: got ben=%b/%b valid=%b, expected 1 1", b0.ben_output, b1.ben_output, b0.ben_valid);
        end
        drive(0, 1, 16'h0000, 3'b101, 0, 0, 0);
        tick();
        checks++;
        if (b0.ben_output !== 1'b0 || b0.ben_valid !== 1'b1 || b1.ben_output !== 1'b0) begin
            errors++;
            $display("FAIL ben_nomatch: got ben=%b/%b valid=%b, expected 0 1", b0.ben_output, b1.ben_output, b0.ben_valid);
        end
        drive(0, 0, 16'h0000, 3'b111, 0, 0, 0);
        tick();
        checks++;
        if (b0.ben_output !== 1'b0 || b0.ben_valid !== 1'b0) begin
            errors++;
            $display("FAIL ben_hold: got ben=%b valid=%b, expected 0 0", b0.ben_output, b0.ben_valid);
        end
    endtask

    task automatic test_bypass();
        drive(1, 0, 16'h0001, 3'b000, 0, 0, 0);
        tick();
        drive(1, 1, 16'h0000, 3'b010, 0, 0, 0);
        tick();
        checks++;
        if (b0.ben_output !== 1'b0) begin
            errors++;
            $display("FAIL bypass_off_ben: got %b, expected 0", b0.ben_output);
        end
        checks++;
        if (b1.ben_output !== 1'b1) begin
            errors++;
            $display("FAIL bypass_on_ben: got %b, expected 1", b1.ben_output);
        end
        checks++;
        if (b0.nzp !== 3'b010 || b1.nzp !== 3'b010 || b0.ben_valid !== 1'b1 || b1.ben_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass_nzp: got nzp=%b/%b valid=%b/%b, expected 010 1",
                     b0.nzp, b1.nzp, b0.ben_valid, b1.ben_valid);
        end
    endtask

    task automatic test_stack();
        nzp_t exp_pop [4];
        exp_pop = '{3'b100, 3'b001, 3'b010, 3'b100};
        drive(1, 0, 16'h8000, 3'b000, 0, 0, 0);
        tick();
        // Saves 100, 010, 001 while loading the next code, then a plain push of 100.
        drive(1, 0, 16'h0000, 3'b000, 1, 0, 0); tick();
        drive(1, 0, 16'h0001, 3'b000, 1, 0, 0); tick();
        drive(1, 0, 16'h8000, 3'b000, 1, 0, 0); tick();
        checks++;
        if (b0.cc_depth !== 3'd3 || b0.stack_full !== 1'b0 || b0.nzp !== 3'b100) begin
            errors++;
            $display("FAIL stack_depth3: got depth=%0d full=%b nzp=%b, expected 3 0 100",
                     b0.cc_depth, b0.stack_full, b0.nzp);
        end
        drive(0, 0, 16'h0000, 3'b000, 1, 0, 0); tick();
        checks++;
        if (b0.cc_depth !== 3'd4 || b0.stack_full !== 1'b1 || b0.stack_empty !== 1'b0 || b0.ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL stack_full: got depth=%0d full=%b empty=%b ovf=%b, expected 4 1 0 0",
                     b0.cc_depth, b0.stack_full, b0.stack_empty, b0.ovf_err);
        end
        drive(1, 0, 16'h0000, 3'b000, 1, 0, 0); tick();
        checks++;
        if (b0.ovf_err !== 1'b1 || b0.cc_depth !== 3'd4 || b0.nzp !== 3'b010) begin
            errors++;
            $display("FAIL stack_overflow: got ovf=%b depth=%0d nzp=%b, expected 1 4 010",
                     b0.ovf_err, b0.cc_depth, b0.nzp);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 16'h0000, 3'b000, 0, 1, 0);
            tick();
            checks++;
            if (b0.nzp !== exp_pop[i] || b1.nzp !== exp_pop[i] || b0.cc_depth !== 3'(3 - i)) begin
                errors++;
                $display("FAIL stack_pop_%0d: got nzp=%b depth=%0d, expected %b %0d",
                         i, b0.nzp, b0.cc_depth, exp_pop[i], 3 - i);
            end
        end
        drive(0, 0, 16'h0000, 3'b000, 0, 1, 0); tick();
        checks++;
        if (b0.unf_err !== 1'b1 || b0.nzp !== 3'b100 || b0.cc_depth !== 3'd0 ||
            b0.stack_empty !== 1'b1 || b0.ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL stack_underflow: got unf=%b nzp=%b depth=%0d empty=%b ovf=%b, expected 1 100 0 1 1",
                     b0.unf_err, b0.nzp, b0.cc_depth, b0.stack_empty, b0.ovf_err);
        end
        drive(0, 0, 16'h0000, 3'b000, 0, 0, 1); tick();
        checks++;
        if (b0.ovf_err !== 1'b0 || b0.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL stack_err_clr: got ovf=%b unf=%b, expected 0 0", b0.ovf_err, b0.unf_err);
        end
    endtask

    task automatic test_push_ldcc();
        drive(1, 0, 16'h0001, 3'b000, 0, 0, 0); tick();
        drive(1, 0, 16'hFFFF, 3'b000, 1, 0, 0); tick();
        checks++;
        if (b0.nzp !== 3'b100 || b0.cc_depth !== 3'd1) begin
            errors++;
            $display("FAIL push_ldcc: got nzp=%b depth=%0d, expected 100 1", b0.nzp, b0.cc_depth);
        end
        drive(1, 0, 16'h0000, 3'b000, 0, 1, 0); tick();
        checks++;
        if (b0.nzp !== 3'b001 || b1.nzp !== 3'b001 || b0.cc_depth !== 3'd0) begin
            errors++;
            $display("FAIL pop_wins: got nzp=%b/%b depth=%0d, expected 001 0", b0.nzp, b1.nzp, b0.cc_depth);
        end
        drive(0, 0, 16'h0000, 3'b000, 1, 0, 0); tick();
        drive(1, 0, 16'h8000, 3'b000, 1, 1, 0); tick();
        checks++;
        if (b0.ovf_err !== 1'b1 || b0.unf_err !== 1'b0 || b0.cc_depth !== 3'd1 || b0.nzp !== 3'b100) begin
            errors++;
            $display("FAIL push_pop_same: got ovf=%b unf=%b depth=%0d nzp=%b, expected 1 0 1 100",
                     b0.ovf_err, b0.unf_err, b0.cc_depth, b0.nzp);
        end
        drive(0, 0, 16'h0000, 3'b000, 0, 1, 0); tick();
        checks++;
        if (b0.nzp !== 3'b001 || b0.cc_depth !== 3'd0) begin
            errors++;
            $display("FAIL pop_after_pair: got nzp=%b depth=%0d, expected 001 0", b0.nzp, b0.cc_depth);
        end
        drive(0, 0, 16'h0000, 3'b000, 0, 1, 1); tick();
        checks++;
        if (b0.ovf_err !== 1'b0 || b0.unf_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_new_err: got ovf=%b unf=%b, expected 0 1", b0.ovf_err, b0.unf_err);
        end
        drive(0, 0, 16'h0000, 3'b000, 0, 0, 1); tick();
        checks++;
        if (b0.ovf_err !== 1'b0 || b0.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_only: got ovf=%b unf=%b, expected 0 0", b0.ovf_err, b0.unf_err);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 16'h0001, 3'b000, 0, 0, 0); tick();
        drive(0, 0, 16'h0000, 3'b000, 1, 0, 0); tick();
        drive(0, 0, 16'h0000, 3'b000, 1, 0, 0); tick();
        drive(0, 1, 16'h0000, 3'b001, 0, 0, 0); tick();
        checks++;
        if (b0.cc_depth !== 3'd2 || b0.ben_output !== 1'b1 || b0.ben_valid !== 1'b1 || b0.nzp !== 3'b001) begin
            errors++;
            $display("FAIL pre_reset: got depth=%0d ben=%b valid=%b nzp=%b, expected 2 1 1 001",
                     b0.cc_depth, b0.ben_output, b0.ben_valid, b0.nzp);
        end
        drive(0, 0, 16'h0000, 3'b000, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (b0.nzp !== 3'b010 || b0.ben_output !== 1'b0 || b0.ben_valid !== 1'b0 ||
            b0.cc_depth !== 3'd0 || b0.stack_empty !== 1'b1 || b1.nzp !== 3'b010 || b1.ben_output !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got nzp=%b ben=%b valid=%b depth=%0d empty=%b, expected 010 0 0 0 1",
                     b0.nzp, b0.ben_output, b0.ben_valid, b0.cc_depth, b0.stack_empty);
        end
        tick();
        reset_n = 1'b1;
        drive(0, 0, 16'h0000, 3'b000, 0, 1, 0); tick();
        checks++;
        if (b0.unf_err !== 1'b1 || b0.cc_depth !== 3'd0 || b0.nzp !== 3'b010) begin
            errors++;
            $display("FAIL post_reset_pop: got unf=%b depth=%0d nzp=%b, expected 1 0 010",
                     b0.unf_err, b0.cc_depth, b0.nzp);
        end
        drive(0, 0, 16'h0000, 3'b000, 0, 0, 0); tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(0, 0, 16'h0000, 3'b000, 0, 0, 0);
        test_reset();
        test_classify();
        test_ben();
        test_bypass();
        test_stack();
        test_push_ldcc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
